// File: rtl/cronometro_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// Presets are stored as BCD minutes (MM); seconds always load as 00.
package cronometro_pkg;

  typedef enum logic [1:0] {
    MODO_OFF           = 2'd0,
    MODO_GOTEJAMENTO   = 2'd1,
    MODO_ASPERSAO      = 2'd2,
    MODO_PERSONALIZADO = 2'd3
  } modo_e;

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused
  } estado_e;

  localparam logic [7:0] PRESET_GOTEJAMENTO = 8'h30;
  localparam logic [7:0] PRESET_ASPERSAO    = 8'h12;
  localparam logic [7:0] BCD_CLAMP          = 8'h59;

  localparam int unsigned NUM_LIMIARES = 3;
  localparam int unsigned LIMIAR_NIVEL [NUM_LIMIARES] = '{6, 12, 30};

  // Level bits beyond the table never assert.
  function automatic int unsigned limiar(input int unsigned i);
    if (i < NUM_LIMIARES) return LIMIAR_NIVEL[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] preset_minutos(input modo_e      modo,
                                                input logic [3:0] dez,
                                                input logic [3:0] uni);
    case (modo)
      MODO_GOTEJAMENTO:   return PRESET_GOTEJAMENTO;
      MODO_ASPERSAO:      return PRESET_ASPERSAO;
      MODO_PERSONALIZADO: begin
        if (dez > 4'd5 || uni > 4'd9) return BCD_CLAMP;
        return {dez, uni};
      end
      default:            return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/contador_bcd_dec.sv
// Single down-counting BCD digit with synchronous load and borrow chaining.
// borrow_o is combinational so a chain of digits decrements in one cycle.
module contador_bcd_dec #(
  parameter int unsigned Modulo = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       carga_i,
  input  logic [3:0] valor_i,
  input  logic       en_i,
  input  logic       borrow_i,
  output logic [3:0] digito_o,
  output logic       borrow_o
);

  localparam logic [3:0] DigMax = 4'(Modulo - 1);

  logic [3:0] digito_q, digito_d;

  always_comb begin
    digito_d = digito_q;
    if (carga_i) begin
      digito_d = valor_i;
    end else if (en_i && borrow_i) begin
      digito_d = (digito_q == 4'd0) ? DigMax : digito_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digito_q <= 4'd0;
    end else begin
      digito_q <= digito_d;
    end
  end

  assign digito_o = digito_q;
  assign borrow_o = borrow_i && (digito_q == 4'd0);

endmodule

// File: rtl/cronometro_irrigacao.sv
// Irrigation countdown: loads a per-mode MM:SS preset, counts down on second
// events, drives the valve while running and reports elapsed-water level.
module cronometro_irrigacao
  import cronometro_pkg::*;
#(
  parameter int unsigned TICKS_POR_SEGUNDO = 1,
  parameter int unsigned NIVEIS            = 3,
  parameter int unsigned MIN_W             = 8
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              tick_i,
  input  logic [1:0]        modo_i,
  input  logic [3:0]        presetDezMin_i,
  input  logic [3:0]        presetUniMin_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              abort_i,
  output logic [3:0]        dezenaMinuto_o,
  output logic [3:0]        unidadeMinuto_o,
  output logic [3:0]        dezenaSegundos_o,
  output logic [3:0]        unidadeSegundos_o,
  output logic              valvula_o,
  output logic              ocupado_o,
  output logic              fim_o,
  output logic [NIVEIS-1:0] nivelDagua_o
);

  localparam int unsigned    PreW   = (TICKS_POR_SEGUNDO > 1) ? $clog2(TICKS_POR_SEGUNDO) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICKS_POR_SEGUNDO - 1);

  estado_e           estado_q;
  logic [PreW-1:0]   pre_q;
  logic [MIN_W-1:0]  min_q;
  logic [NIVEIS-1:0] nivel_q;
  logic              fim_q;

  logic [7:0]        preset;
  logic              carregar, abortar, evento_seg, decrementar;
  logic              virada_min, chega_zero, carga;
  logic [15:0]       carga_val;
  logic [MIN_W-1:0]  min_prox;
  logic [NIVEIS-1:0] nivel_prox;

  logic [3:0]        dig_dm, dig_um, dig_ds, dig_us;
  logic              b_us, b_ds, b_um, b_dm;

  always_comb begin
    preset      = preset_minutos(modo_e'(modo_i), presetDezMin_i, presetUniMin_i);
    carregar    = (estado_q == StIdle) && start_i && (modo_e'(modo_i) != MODO_OFF);
    abortar     = (estado_q != StIdle) && abort_i;
    evento_seg  = tick_i && (pre_q == PreMax);
    // b_dm is high only at 00:00, which RUNNING never holds; guard anyway.
    decrementar = (estado_q == StRunning) && !abort_i && !pause_i && evento_seg && !b_dm;
    carga       = carregar || abortar;
    carga_val   = carregar ? {preset, 8'h00} : 16'h0000;
    virada_min  = b_ds;
    chega_zero  = {dig_dm, dig_um, dig_ds, dig_us} == 16'h0001;
    min_prox    = (min_q == '1) ? min_q : min_q + 1'b1;
    nivel_prox  = '0;
    for (int unsigned i = 0; i < NIVEIS; i++) begin
      nivel_prox[i] = 32'(min_prox) >= limiar(i);
    end
  end

  contador_bcd_dec #(.Modulo(10)) u_uni_seg (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .carga_i  (carga),
    .valor_i  (carga_val[3:0]),
    .en_i     (decrementar),
    .borrow_i (1'b1),
    .digito_o (dig_us),
    .borrow_o (b_us)
  );

  contador_bcd_dec #(.Modulo(6)) u_dez_seg (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .carga_i  (carga),
    .valor_i  (carga_val[7:4]),
    .en_i     (decrementar),
    .borrow_i (b_us),
    .digito_o (dig_ds),
    .borrow_o (b_ds)
  );

  contador_bcd_dec #(.Modulo(10)) u_uni_min (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .carga_i  (carga),
    .valor_i  (carga_val[11:8]),
    .en_i     (decrementar),
    .borrow_i (b_ds),
    .digito_o (dig_um),
    .borrow_o (b_um)
  );

  contador_bcd_dec #(.Modulo(10)) u_dez_min (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .carga_i  (carga),
    .valor_i  (carga_val[15:12]),
    .en_i     (decrementar),
    .borrow_i (b_um),
    .digito_o (dig_dm),
    .borrow_o (b_dm)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q <= StIdle;
      pre_q    <= '0;
      min_q    <= '0;
      nivel_q  <= '0;
      fim_q    <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      unique case (estado_q)
        StIdle: begin
          if (carregar) begin
            pre_q   <= '0;
            min_q   <= '0;
            nivel_q <= '0;
            if (preset == 8'h00) fim_q    <= 1'b1;
            else                 estado_q <= StRunning;
          end
        end
        StRunning: begin
          if (abort_i) begin
            estado_q <= StIdle;
          end else if (pause_i) begin
            estado_q <= StPaused;
          end else if (tick_i) begin
            if (evento_seg) begin
              pre_q <= '0;
              if (decrementar && virada_min) begin
                min_q   <= min_prox;
                nivel_q <= nivel_prox;
              end
              if (decrementar && chega_zero) begin
                estado_q <= StIdle;
                fim_q    <= 1'b1;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
        end
        StPaused: begin
          if (abort_i)       estado_q <= StIdle;
          else if (!pause_i) estado_q <= StRunning;
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

  assign dezenaMinuto_o    = dig_dm;
  assign unidadeMinuto_o   = dig_um;
  assign dezenaSegundos_o  = dig_ds;
  assign unidadeSegundos_o = dig_us;
  assign valvula_o         = (estado_q == StRunning);
  assign ocupado_o         = (estado_q == StRunning) || (estado_q == StPaused);
  assign fim_o             = fim_q;
  assign nivelDagua_o      = nivel_q;

endmodule

// File: tb/tb_cronometro_irrigacao.sv
// Directed bench: one task per scenario, two DUTs (1 and 4 ticks per second).
module tb_cronometro_irrigacao;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic       tick, start, pause, abort;
  logic [1:0] modo;
  logic [3:0] pdez, puni;
  logic [3:0] dm, um, ds, us;
  logic       valv, ocup, fim;
  logic [2:0] nivel;
  logic [15:0] digs;
  assign digs = {dm, um, ds, us};

  logic       tick4, start4, pause4, abort4;
  logic [1:0] modo4;
  logic [3:0] pdez4, puni4;
  logic [3:0] dm4, um4, ds4, us4;
  logic       valv4, ocup4, fim4;
  logic [2:0] nivel4;
  logic [15:0] digs4;
  assign digs4 = {dm4, um4, ds4, us4};

  int checks   = 0;
  int failures = 0;

  cronometro_irrigacao #(.TICKS_POR_SEGUNDO(1), .NIVEIS(3), .MIN_W(8)) dut (
    .clock_i           (clock),
    .reset_ni          (reset_n),
    .tick_i            (tick),
    .modo_i            (modo),
    .presetDezMin_i    (pdez),
    .presetUniMin_i    (puni),
    .start_i           (start),
    .pause_i           (pause),
    .abort_i           (abort),
    .dezenaMinuto_o    (dm),
    .unidadeMinuto_o   (um),
    .dezenaSegundos_o  (ds),
    .unidadeSegundos_o (us),
    .valvula_o         (valv),
    .ocupado_o         (ocup),
    .fim_o             (fim),
    .nivelDagua_o      (nivel)
  );

  cronometro_irrigacao #(.TICKS_POR_SEGUNDO(4), .NIVEIS(3), .MIN_W(8)) dut4 (
    .clock_i           (clock),
    .reset_ni          (reset_n),
    .tick_i            (tick4),
    .modo_i            (modo4),
    .presetDezMin_i    (pdez4),
    .presetUniMin_i    (puni4),
    .start_i           (start4),
    .pause_i           (pause4),
    .abort_i           (abort4),
    .dezenaMinuto_o    (dm4),
    .unidadeMinuto_o   (um4),
    .dezenaSegundos_o  (ds4),
    .unidadeSegundos_o (us4),
    .valvula_o         (valv4),
    .ocupado_o         (ocup4),
    .fim_o             (fim4),
    .nivelDagua_o      (nivel4)
  );

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic carregar1(input logic [1:0] m, input logic [3:0] d, input logic [3:0] u);
    modo = m; pdez = d; puni = u; start = 1'b1;
    ciclo();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({digs, valv, ocup, fim, nivel} !== 22'd0) begin
      failures++;
      $display("FAIL reset_inicial got=%h expected=0", {digs, valv, ocup, fim, nivel});
    end
    @(negedge clock) reset_n = 1'b1;
    ciclo();
    // 08:00 minus 47 s = 07:13
    carregar1(2'd3, 4'd0, 4'd8);
    tick = 1'b1;
    repeat (47) ciclo();
    tick = 1'b0;
    checks++;
    if (digs !== 16'h0713 || ocup !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_0713 got digs=%h ocup=%b expected 0713/1", digs, ocup);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({digs, valv, ocup, fim, nivel} !== 22'd0) begin
      failures++;
      $display("FAIL reset_assincrono got=%h expected=0", {digs, valv, ocup, fim, nivel});
    end
    @(negedge clock) reset_n = 1'b1;
    tick = 1'b1;
    ciclo();
    tick = 1'b0;
    checks++;
    if (digs !== 16'h0000 || ocup !== 1'b0 || valv !== 1'b0) begin
      failures++;
      $display("FAIL idle_pos_reset got digs=%h ocup=%b valv=%b expected 0000/0/0",
               digs, ocup, valv);
    end
  endtask

  task automatic test_modo1_completo();
    logic [20:0] obs, exp_v;
    int rem, mm, ss, el;
    logic [2:0] en;
    carregar1(2'd1, 4'd0, 4'd0);
    checks++;
    if ({digs, valv, ocup, fim, nivel} !== {16'h3000, 3'b110, 3'b000}) begin
      failures++;
      $display("FAIL modo1_carga got digs=%h v=%b o=%b f=%b n=%b expected 3000/1/1/0/000",
               digs, valv, ocup, fim, nivel);
    end
    tick = 1'b1;
    for (int k = 1; k <= 1800; k++) begin
      ciclo();
      rem = 1800 - k;
      mm  = rem / 60;
      ss  = rem % 60;
      el  = (k + 59) / 60;
      en  = {el >= 30, el >= 12, el >= 6};
      exp_v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), en,
               (k < 1800) ? 1'b1 : 1'b0, (k == 1800) ? 1'b1 : 1'b0};
      obs = {digs, nivel, valv, fim};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL modo1_tick%0d got digs=%h n=%b v=%b f=%b expected digs=%h n=%b v=%b f=%b",
                 k, obs[20:5], obs[4:2], obs[1], obs[0],
                 exp_v[20:5], exp_v[4:2], exp_v[1], exp_v[0]);
      end
    end
    tick = 1'b0;
    ciclo();
    checks++;
    if ({digs, valv, ocup, fim, nivel} !== {16'h0000, 3'b000, 3'b111}) begin
      failures++;
      $display("FAIL modo1_pos_fim got digs=%h v=%b o=%b f=%b n=%b expected 0000/0/0/0/111",
               digs, valv, ocup, fim, nivel);
    end
  endtask

  task automatic test_modo3_clamp();
    carregar1(2'd3, 4'hA, 4'd3);
    checks++;
    if (digs !== 16'h5900 || ocup !== 1'b1 || nivel !== 3'b000) begin
      failures++;
      $display("FAIL clamp_nao_bcd got digs=%h o=%b n=%b expected 5900/1/000", digs, ocup, nivel);
    end
    tick = 1'b1;
    ciclo();
    checks++;
    if (digs !== 16'h5859) begin
      failures++;
      $display("FAIL clamp_primeiro_tick got=%h expected=5859", digs);
    end
    repeat (299) ciclo();
    checks++;
    if (digs !== 16'h5400 || nivel !== 3'b000) begin
      failures++;
      $display("FAIL clamp_5400 got digs=%h n=%b expected 5400/000", digs, nivel);
    end
    ciclo();
    tick = 1'b0;
    checks++;
    if (digs !== 16'h5359 || nivel !== 3'b001) begin
      failures++;
      $display("FAIL clamp_sexto_minuto got digs=%h n=%b expected 5359/001", digs, nivel);
    end
    abort = 1'b1;
    ciclo();
    abort = 1'b0;
    checks++;
    if ({digs, valv, ocup, fim, nivel} !== {16'h0000, 3'b000, 3'b001}) begin
      failures++;
      $display("FAIL abort_mantem_nivel got digs=%h v=%b o=%b f=%b n=%b expected 0000/0/0/0/001",
               digs, valv, ocup, fim, nivel);
    end
    carregar1(2'd3, 4'd6, 4'd5);
    checks++;
    if (digs !== 16'h5900 || nivel !== 3'b000) begin
      failures++;
      $display("FAIL clamp_dezena_6 got digs=%h n=%b expected 5900/000", digs, nivel);
    end
    abort = 1'b1;
    ciclo();
    abort = 1'b0;
  endtask

  task automatic test_preset_zero();
    carregar1(2'd3, 4'd0, 4'd0);
    checks++;
    if ({digs, valv, ocup, fim} !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL zero_fim_na_carga got digs=%h v=%b o=%b f=%b expected 0000/0/0/1",
               digs, valv, ocup, fim);
    end
    ciclo();
    checks++;
    if ({valv, ocup, fim} !== 3'b000) begin
      failures++;
      $display("FAIL zero_fim_um_ciclo got v=%b o=%b f=%b expected 0/0/0", valv, ocup, fim);
    end
    carregar1(2'd0, 4'd1, 4'd0);
    checks++;
    if ({digs, ocup, fim} !== {16'h0000, 2'b00}) begin
      failures++;
      $display("FAIL modo0_ignora_start got digs=%h o=%b f=%b expected 0000/0/0", digs, ocup, fim);
    end
  endtask

  task automatic test_pausa();
    carregar1(2'd2, 4'd0, 4'd0);
    pause = 1'b1;
    tick  = 1'b1;
    ciclo();
    tick  = 1'b0;
    checks++;
    if (digs !== 16'h1200 || valv !== 1'b0 || ocup !== 1'b1) begin
      failures++;
      $display("FAIL pausa_com_tick got digs=%h v=%b o=%b expected 1200/0/1", digs, valv, ocup);
    end
    modo  = 2'd1;
    start = 1'b1;
    repeat (5) begin
      tick = 1'b1; ciclo();
      tick = 1'b0; ciclo();
    end
    start = 1'b0;
    checks++;
    if (digs !== 16'h1200 || ocup !== 1'b1 || fim !== 1'b0) begin
      failures++;
      $display("FAIL pausa_5_ticks got digs=%h o=%b f=%b expected 1200/1/0", digs, ocup, fim);
    end
    pause = 1'b0;
    ciclo();
    checks++;
    if (digs !== 16'h1200 || valv !== 1'b1) begin
      failures++;
      $display("FAIL pausa_liberada got digs=%h v=%b expected 1200/1", digs, valv);
    end
    tick = 1'b1;
    ciclo();
    tick = 1'b0;
    checks++;
    if (digs !== 16'h1159) begin
      failures++;
      $display("FAIL retoma_1159 got=%h expected=1159", digs);
    end
    abort = 1'b1;
    ciclo();
    abort = 1'b0;
  endtask

  task automatic test_prescaler4();
    logic [15:0] esperado;
    modo4 = 2'd2; start4 = 1'b1;
    ciclo();
    start4 = 1'b0;
    checks++;
    if (digs4 !== 16'h1200 || valv4 !== 1'b1) begin
      failures++;
      $display("FAIL pre4_carga got digs=%h v=%b expected 1200/1", digs4, valv4);
    end
    for (int n = 1; n <= 8; n++) begin
      tick4 = 1'b1; ciclo();
      tick4 = 1'b0;
      esperado = (n < 4) ? 16'h1200 : (n < 8) ? 16'h1159 : 16'h1158;
      checks++;
      if (digs4 !== esperado) begin
        failures++;
        $display("FAIL pre4_tick%0d got=%h expected=%h", n, digs4, esperado);
      end
      ciclo();
    end
    abort4 = 1'b1;
    ciclo();
    abort4 = 1'b0;
    checks++;
    if ({digs4, valv4, ocup4, fim4, nivel4} !== 22'd0) begin
      failures++;
      $display("FAIL pre4_abort got digs=%h v=%b o=%b f=%b n=%b expected 0000/0/0/0/000",
               digs4, valv4, ocup4, fim4, nivel4);
    end
    ciclo();
    checks++;
    if (fim4 !== 1'b0 || ocup4 !== 1'b0) begin
      failures++;
      $display("FAIL pre4_sem_fim got f=%b o=%b expected 0/0", fim4, ocup4);
    end
  endtask

  initial begin
    tick = 0; start = 0; pause = 0; abort = 0; modo = 0; pdez = 0; puni = 0;
    tick4 = 0; start4 = 0; pause4 = 0; abort4 = 0; modo4 = 0; pdez4 = 0; puni4 = 0;
    test_reset();
    test_modo1_completo();
    test_modo3_clamp();
    test_preset_zero();
    test_pausa();
    test_prescaler4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
